adder4_share_sched: RTL
=======================

# adder4_share_sched

Round-robin scheduler that time-shares one pipelined four-operand adder (carry-save 4:2 encoder plus carry-lookahead final adder, `L` register stages) among `NReq` requesters. It sits between the requesting datapath blocks and the shared adder instance:
- accepts operand sets with a valid/ready handshake;
- issues at most one set per cycle;
- tracks every in-flight operation with a tag pipeline;
- returns each sum, tagged with the requester ID, exactly `L` cycles after issue.

It also supports locked bursts, so one requester can own the adder for several back-to-back beats.

## Interface
Parameters:
- `Width`, 32 — operand/sum width; allowed values 4, 8, 16, 32.
- `NReq`, 4 — number of requesters; allowed range 2..8.
- `L`, 3 — register latency of the shared adder in cycles; allowed range 1..8; must match the adder's stage configuration.

Ports:
- `i_clkp` in 1 — clock, rising edge.
- `i_rstn` in 1 — reset, asynchronous, active-low.
- `i_req_valid` in NReq — per-requester operand set valid.
- `i_req_last` in NReq — per-requester: this beat ends the burst.
- `i_req_ops` in NReq*4*Width — operand sets. Requester i, operand j is at `[(i*4+j)*Width +: Width]`, with j=0 y, 1 z, 2 a, 3 b.
- `i_req_cin` in NReq — per-requester carry-in.
- `o_req_ready` in-direction out, NReq — one-hot grant, or all zero.
- `o_add_y`, `o_add_z`, `o_add_a`, `o_add_b` out Width — operands driven to the shared adder.
- `o_add_c` out 1 — carry-in driven to the shared adder.
- `i_add_d` in Width, `i_add_c` in 1 — adder sum and carry-out, arriving L cycles after issue.
- `o_res_valid` out 1; `o_res_id` out clog2(NReq); `o_res_d` out Width; `o_res_c` out 1 — result broadcast. Results have no backpressure.
- `o_inflight` out clog2(L+1) — number of operations currently in the adder.
- `o_locked` out 1 — high while a burst owns the adder.

## Operation
- **Handshake:** a transfer occurs on an edge where `i_req_valid[i] & o_req_ready[i]`. `o_req_ready` is combinational from `i_req_valid`, the FSM state and the round-robin pointer.
- **Operand mux:** `o_add_*` are combinationally muxed from the granted requester. When nothing is granted they are driven to zero.

**FSM states: ARB and LOCK.**
- **ARB:**
  - Grant the first valid requester at or after `rr_ptr`, searching upward with wrap.
  - On a transfer with `last=1`: `rr_ptr` ← winner+1 (mod NReq); stay in ARB.
  - On a transfer with `last=0`: `owner` ← winner; go to LOCK.
- **LOCK:**
  - `o_req_ready` = `owner` bit only, gated by `i_req_valid[owner]`. All other requesters see ready=0.
  - If the owner drops valid, the adder idles; the state stays LOCK.
  - A transfer with `last=1` → ARB, with `rr_ptr` ← owner+1.
- **Tag pipeline:** L stages of {valid, id}. Stage 0 loads {transfer, winner id} every cycle; idle cycles load valid=0.
- **Results:** `o_res_valid`/`o_res_id` come from tag stage L-1. `o_res_d`/`o_res_c` are pass-through of `i_add_d`/`i_add_c`. When `o_res_valid=0`, `o_res_d` and `o_res_c` are zero.
- **In-flight count:** `o_inflight` = popcount of the tag valids. It is maintained as a counter: +1 on issue, -1 on retire, and unchanged when both occur in the same cycle.
- **Arithmetic:** sum = y+z+a+b+cin mod 2^Width. The scheduler never alters data; the carry semantics belong to the adder.

## Timing
- **Reset values** (asynchronous, immediate): state=ARB, `rr_ptr`=0, `owner`=0, all tag valids=0, `o_res_valid`=0, `o_res_id`=0, `o_res_d`=0, `o_res_c`=0, `o_inflight`=0, `o_locked`=0.
- **Latency:** a transfer on edge k produces `o_res_valid` in the cycle after edge k+L-1, i.e. an L-cycle issue-to-result delay.
- **Throughput:** one operation per cycle sustained, with no bubbles between requesters or between burst beats.
- **Simultaneous issue and retire:** `o_inflight` is unchanged.
- **Reset mid-operation:** in-flight results are discarded (no `o_res_valid`), and any lock is dropped.
- **Invalid request:** `i_req_last` is ignored unless a transfer occurs.
- **Single requester:** it may issue every cycle; `rr_ptr` still updates.

## Structure
- **Package `adder4_sched_pkg`:** state enum {ARB, LOCK} and the function `idw(NReq)` = clog2(NReq).
- **Sub-module `rr_arbiter`:** inputs are the request vector and pointer; outputs are the one-hot grant and the encoded id. It is purely combinational and is also used in LOCK with a single-bit mask.
- **Top level:** the FSM, tag shift register and in-flight counter live in the top. The shared adder stays outside the block.

## Test plan
- NReq=4, L=3, all requesters valid with last=1 for 8 cycles → grants 0,1,2,3,0,1,2,3. Results arrive 3 cycles after each issue with ids in the same order; with y=i, z=1, a=2, b=3, cin=0, requester i's sum is i+6.
- Requester 2 sends a burst of 3 beats (last=0,0,1) while 0 and 1 are valid → 2,2,2 granted consecutively, `o_locked` high for 2 cycles, then grant goes to 3 if valid, else 0.
- Locked owner drops valid for 2 cycles mid-burst → no grants, `o_inflight` decays, lock holds, and the burst resumes afterwards.
- Width=8, all operands 0xFF, cin=1 → `o_res_d`=0xFD, `o_res_c` passed through from the adder; overflow wraps.
- `i_rstn` asserted with 3 operations in flight → outputs zero immediately and no stale `o_res_valid` appears after release.
- Continuous issue plus retire → `o_inflight` holds at 3 (=L) steady state.

Source files
------------

// File: rtl/adder4_share_sched_pkg.sv
// rtl/adder4_share_sched_pkg.sv - shared types and helpers for the adder scheduler
package adder4_sched_pkg;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Width of a requester id; a single requester still needs one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder4_share_sched_if.sv
// rtl/adder4_share_sched_if.sv - requester, shared-adder and result signals of the scheduler
interface adder4_share_sched_if #(
  parameter int Width = 32,
  parameter int NReq  = 4,
  parameter int L     = 3
);
  import adder4_sched_pkg::*;

  localparam int IdW = idw(NReq);
  localparam int IfW = $clog2(L + 1);

  logic [NReq-1:0]         i_req_valid;
  logic [NReq-1:0]         i_req_last;
  logic [NReq*4*Width-1:0] i_req_ops;
  logic [NReq-1:0]         i_req_cin;
  logic [NReq-1:0]         o_req_ready;
  logic [Width-1:0]        o_add_y;
  logic [Width-1:0]        o_add_z;
  logic [Width-1:0]        o_add_a;
  logic [Width-1:0]        o_add_b;
  logic                    o_add_c;
  logic [Width-1:0]        i_add_d;
  logic                    i_add_c;
  logic                    o_res_valid;
  logic [IdW-1:0]          o_res_id;
  logic [Width-1:0]        o_res_d;
  logic                    o_res_c;
  logic [IfW-1:0]          o_inflight;
  logic                    o_locked;

  modport master (
    output i_req_valid, i_req_last, i_req_ops, i_req_cin, i_add_d, i_add_c,
    input  o_req_ready, o_add_y, o_add_z, o_add_a, o_add_b, o_add_c,
    input  o_res_valid, o_res_id, o_res_d, o_res_c, o_inflight, o_locked
  );

  modport slave (
    input  i_req_valid, i_req_last, i_req_ops, i_req_cin, i_add_d, i_add_c,
    output o_req_ready, o_add_y, o_add_z, o_add_a, o_add_b, o_add_c,
    output o_res_valid, o_res_id, o_res_d, o_res_c, o_inflight, o_locked
  );

endinterface

// File: rtl/adder4_share_sched_rr_arbiter.sv
// rtl/adder4_share_sched_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter
  import adder4_sched_pkg::*;
#(
  parameter  int NReq = 4,
  localparam int IdW  = idw(NReq)
) (
  input  logic [NReq-1:0] req,
  input  logic [IdW-1:0]  ptr,
  output logic [NReq-1:0] gnt,
  output logic [IdW-1:0]  id
);

  logic           found;
  int             idx;
  logic [IdW-1:0] sel;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NReq; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NReq) idx = idx - NReq;
      sel = idx[IdW-1:0];
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        id       = sel;
      end
    end
  end

endmodule

// File: rtl/adder4_share_sched.sv
// rtl/adder4_share_sched.sv - round-robin scheduler time-sharing one pipelined 4-operand adder
module adder4_share_sched
  import adder4_sched_pkg::*;
#(
  parameter int Width = 32,
  parameter int NReq  = 4,
  parameter int L     = 3
) (
  input logic                 i_clkp,
  input logic                 i_rstn,
  adder4_share_sched_if.slave bus
);

  localparam int IdW = idw(NReq);
  localparam int IfW = $clog2(L + 1);
  localparam logic [0:0] ST_ARB  = ARB;
  localparam logic [0:0] ST_LOCK = LOCK;

  logic [0:0]      state;
  logic [IdW-1:0]  rr_ptr;
  logic [IdW-1:0]  owner;
  logic [NReq-1:0] arb_req;
  logic [NReq-1:0] gnt;
  logic [IdW-1:0]  arb_ptr;
  logic [IdW-1:0]  win_id;
  logic [IdW-1:0]  next_ptr;
  logic            xfer;
  logic            xfer_last;
  logic [L-1:0]    tag_v;
  logic [IdW-1:0]  tag_id [L];
  logic [IfW-1:0]  inflight;

  // A burst owner is the only candidate; nobody is granted while reset is held.
  always_comb begin
    if (state == ST_LOCK) begin
      arb_req = bus.i_req_valid & (NReq'(1) << owner);
      arb_ptr = owner;
    end else begin
      arb_req = bus.i_req_valid;
      arb_ptr = rr_ptr;
    end
    if (!i_rstn) arb_req = '0;
  end

  rr_arbiter #(.NReq(NReq)) u_arb (
    .req(arb_req),
    .ptr(arb_ptr),
    .gnt(gnt),
    .id (win_id)
  );

  assign xfer      = |gnt;
  assign xfer_last = bus.i_req_last[win_id];
  assign next_ptr  = (win_id == IdW'(NReq - 1)) ? '0 : win_id + 1'b1;

  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= ST_ARB;
      rr_ptr <= '0;
      owner  <= '0;
    end else if (xfer) begin
      if (xfer_last) begin
        state  <= ST_ARB;
        rr_ptr <= next_ptr;
      end else begin
        state <= ST_LOCK;
        owner <= win_id;
      end
    end
  end

  // Stage s holds the operation issued s+1 edges ago; idle cycles shift in bubbles.
  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      tag_v <= '0;
      for (int s = 0; s < L; s++) tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= xfer;
      tag_id[0] <= win_id;
      for (int s = 1; s < L; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      inflight <= '0;
    end else if (xfer && !tag_v[L-1]) begin
      inflight <= inflight + 1'b1;
    end else if (!xfer && tag_v[L-1]) begin
      inflight <= inflight - 1'b1;
    end
  end

  always_comb begin
    bus.o_add_y = '0;
    bus.o_add_z = '0;
    bus.o_add_a = '0;
    bus.o_add_b = '0;
    bus.o_add_c = 1'b0;
    if (xfer) begin
      bus.o_add_y = bus.i_req_ops[(int'(win_id) * 4 + 0) * Width +: Width];
      bus.o_add_z = bus.i_req_ops[(int'(win_id) * 4 + 1) * Width +: Width];
      bus.o_add_a = bus.i_req_ops[(int'(win_id) * 4 + 2) * Width +: Width];
      bus.o_add_b = bus.i_req_ops[(int'(win_id) * 4 + 3) * Width +: Width];
      bus.o_add_c = bus.i_req_cin[win_id];
    end
  end

  assign bus.o_req_ready = gnt;
  assign bus.o_res_valid = tag_v[L-1];
  assign bus.o_res_id    = tag_v[L-1] ? tag_id[L-1] : '0;
  assign bus.o_res_d     = tag_v[L-1] ? bus.i_add_d : '0;
  assign bus.o_res_c     = tag_v[L-1] & bus.i_add_c;
  assign bus.o_inflight  = inflight;
  assign bus.o_locked    = (state == ST_LOCK);

endmodule
